// File: rtl/conv_pool_pkg.sv
// Shared types and constants for the conv+pool window scheduler.
// Optional stall counter in the top is enabled by CONV_POOL_SCHED_PERF_EN.
package conv_pool_pkg;

  localparam int DEF_IN_DIM   = 14;
  localparam int DEF_CHAN_OUT = 18;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    EMIT   = 2'd2,
    DONE   = 2'd3
  } sched_state_t;

  // Output map side after a 6x6 window at stride 2.
  function automatic int out_dim(input int in_dim);
    return (in_dim - 4) / 2;
  endfunction

endpackage

// File: rtl/conv_pool_scheduler_raster.sv
// Row/column raster counter over a DIM x DIM output map.
// c wraps at DIM-1 and carries into r; clr has priority over adv.
module raster_counter
  import conv_pool_pkg::*;
#(
  parameter int DIM = 5,
  parameter int CW  = (DIM > 1) ? $clog2(DIM) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          adv,
  output logic [CW-1:0] r,
  output logic [CW-1:0] c,
  output logic          last
);

  localparam logic [CW-1:0] MAX_IDX = CW'(DIM - 1);

  logic [CW-1:0] r_row;
  logic [CW-1:0] r_col;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_row <= '0;
      r_col <= '0;
    end else if (adv) begin
      if (r_col == MAX_IDX) begin
        r_col <= '0;
        r_row <= (r_row == MAX_IDX) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign r    = r_row;
  assign c    = r_col;
  assign last = (r_row == MAX_IDX) && (r_col == MAX_IDX);

endmodule

// File: rtl/conv_pool_scheduler.sv
// Steps the conv+pool datapath over every 6x6 window (stride 2) of the map and
// streams each pooled pixel vector out. CONV_POOL_SCHED_PERF_EN adds stall_cycles.
module conv_pool_scheduler
  import conv_pool_pkg::*;
#(
  parameter  int IN_DIM   = DEF_IN_DIM,
  parameter  int CHAN_OUT = DEF_CHAN_OUT,
  parameter  int DP_LAT   = 2,
  localparam int OUT_DIM  = out_dim(IN_DIM),
  localparam int CW       = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                win_valid,
  output logic [CW-1:0]       win_r,
  output logic [CW-1:0]       win_c,
  input  logic [CHAN_OUT-1:0] dp_pixel,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CHAN_OUT-1:0] out_data,
  output logic [CW-1:0]       out_r,
  output logic [CW-1:0]       out_c,
  output logic                out_last,
`ifdef CONV_POOL_SCHED_PERF_EN
  output logic [15:0]         stall_cycles,
`endif
  output sched_state_t        dbg_state
);

  localparam int SW = (DP_LAT > 0) ? $clog2(DP_LAT + 1) : 1;

  sched_state_t        r_state;
  sched_state_t        w_next;
  logic [SW-1:0]       r_settle;
  logic [CHAN_OUT-1:0] r_out_data;
  logic [CW-1:0]       r_out_r;
  logic [CW-1:0]       r_out_c;
  logic                r_out_last;

  logic [CW-1:0] w_r;
  logic [CW-1:0] w_c;
  logic          w_last;
  logic          w_settle_last;
  logic          w_start_acc;
  logic          w_hs;
  logic          w_adv;

  // Output handshake: a result transfers on any cycle with out_valid && out_ready;
  // out_valid never drops and out_data/out_r/out_c/out_last never change until then.
  assign w_settle_last = (r_settle == SW'(DP_LAT));
  assign w_start_acc   = (r_state == IDLE) && start;
  assign w_hs          = (r_state == EMIT) && out_ready;
  assign w_adv         = w_hs && !r_out_last;

  raster_counter #(.DIM(OUT_DIM), .CW(CW)) u_raster (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_start_acc),
    .adv  (w_adv),
    .r    (w_r),
    .c    (w_c),
    .last (w_last)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = SETTLE;
      SETTLE:  if (w_settle_last) w_next = EMIT;
      EMIT:    if (out_ready) w_next = r_out_last ? DONE : SETTLE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Settle counter restarts at 0 on every entry to SETTLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_settle <= '0;
    end else if ((r_state == SETTLE) && !w_settle_last) begin
      r_settle <= r_settle + 1'b1;
    end else begin
      r_settle <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data <= '0;
      r_out_r    <= '0;
      r_out_c    <= '0;
      r_out_last <= 1'b0;
    end else if ((r_state == SETTLE) && w_settle_last) begin
      r_out_data <= dp_pixel;
      r_out_r    <= w_r;
      r_out_c    <= w_c;
      r_out_last <= w_last;
    end
  end

`ifdef CONV_POOL_SCHED_PERF_EN
  logic [15:0] r_stall;

  always_ff @(posedge clk) begin
    if (rst || w_start_acc) begin
      r_stall <= '0;
    end else if ((r_state == EMIT) && !out_ready && (r_stall != 16'hFFFF)) begin
      r_stall <= r_stall + 16'd1;
    end
  end

  assign stall_cycles = r_stall;
`endif

  assign busy      = (r_state == SETTLE) || (r_state == EMIT);
  assign done      = (r_state == DONE);
  assign win_valid = (r_state == SETTLE);
  assign win_r     = w_r;
  assign win_c     = w_c;
  assign out_valid = (r_state == EMIT);
  assign out_data  = r_out_data;
  assign out_r     = r_out_r;
  assign out_c     = r_out_c;
  assign out_last  = r_out_last;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_conv_pool_scheduler.sv
// Directed bench for conv_pool_scheduler: DP_LAT=2 main instance plus a DP_LAT=0 instance.
// Cycle 0 is the cycle in which start is first driven high.
module tb_conv_pool_scheduler;
  import conv_pool_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        out_ready = 1'b1;
  logic        use_const = 1'b0;
  logic [17:0] dp_pixel;
  logic        busy, done, win_valid, out_valid, out_last;
  logic [2:0]  win_r, win_c, out_r, out_c;
  logic [17:0] out_data;
  sched_state_t dbg_state;

  logic        start0 = 1'b0;
  logic        out_ready0 = 1'b1;
  logic [17:0] dp_pixel0;
  logic        busy0, done0, win_valid0, out_valid0, out_last0;
  logic [2:0]  win_r0, win_c0, out_r0, out_c0;
  logic [17:0] out_data0;
  sched_state_t dbg_state0;
`ifdef CONV_POOL_SCHED_PERF_EN
  logic [15:0] stall_cycles, stall_cycles0;
`endif

  int checks = 0;
  int errors = 0;

  int          hs_cyc[$];
  logic [5:0]  hs_rc[$];
  logic [17:0] hs_d[$];
  logic        hs_last[$];
  int          done_q[$];
  logic        busy_q[$];
  logic [17:0] st_d[$];
  logic [5:0]  st_rc[$];
  logic [5:0]  st_win[$];
  logic        st_wv[$];
  logic [5:0]  exp_q[$];

  // Datapath stand-in: pixel derived from the presented window, zero when no window is driven.
  function automatic logic [17:0] pix(input logic [2:0] r, input logic [2:0] c);
    return {6'h15, r, c, 6'h2A};
  endfunction

  assign dp_pixel  = use_const ? 18'h2A5A5 : (win_valid ? pix(win_r, win_c) : 18'h0);
  assign dp_pixel0 = win_valid0 ? pix(win_r0, win_c0) : 18'h0;

  always #5 clk = ~clk;

  conv_pool_scheduler #(.IN_DIM(14), .CHAN_OUT(18), .DP_LAT(2)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .win_valid(win_valid), .win_r(win_r), .win_c(win_c), .dp_pixel(dp_pixel),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_r(out_r), .out_c(out_c), .out_last(out_last),
`ifdef CONV_POOL_SCHED_PERF_EN
    .stall_cycles(stall_cycles),
`endif
    .dbg_state(dbg_state)
  );

  conv_pool_scheduler #(.IN_DIM(14), .CHAN_OUT(18), .DP_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
    .win_valid(win_valid0), .win_r(win_r0), .win_c(win_c0), .dp_pixel(dp_pixel0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
    .out_r(out_r0), .out_c(out_c0), .out_last(out_last0),
`ifdef CONV_POOL_SCHED_PERF_EN
    .stall_cycles(stall_cycles0),
`endif
    .dbg_state(dbg_state0)
  );

  // Drives the main instance for ncyc cycles from a negedge and logs what it observes.
  // start_mode: 0 single pulse, 1 pulse every 3rd cycle while busy, 2 held high.
  task automatic run_pass(input int ncyc, input int stall_idx, input int stall_len,
                          input int start_mode);
    int stalled = 0;
    int hs_n = 0;
    hs_cyc.delete(); hs_rc.delete(); hs_d.delete(); hs_last.delete();
    done_q.delete(); busy_q.delete();
    st_d.delete(); st_rc.delete(); st_win.delete(); st_wv.delete();
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      case (start_mode)
        0:       start = (cyc == 0);
        1:       start = (cyc == 0) || ((cyc % 3 == 0) && (cyc < 90));
        default: start = 1'b1;
      endcase
      if (out_valid && (hs_n == stall_idx) && (stalled < stall_len)) begin
        out_ready = 1'b0;
        stalled++;
        st_d.push_back(out_data);
        st_rc.push_back({out_r, out_c});
        st_win.push_back({win_r, win_c});
        st_wv.push_back(win_valid);
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) begin
        hs_cyc.push_back(cyc);
        hs_rc.push_back({out_r, out_c});
        hs_d.push_back(out_data);
        hs_last.push_back(out_last);
        hs_n++;
      end
      if (done) done_q.push_back(cyc);
      busy_q.push_back(busy);
      @(negedge clk);
    end
    start = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state got %0d exp %0d", dbg_state, IDLE); end
    checks++; if ({busy, done, out_valid, win_valid, out_last} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b exp 00000", {busy, done, out_valid, win_valid, out_last}); end
    checks++; if ({out_data, out_r, out_c, win_r, win_c} !== 30'h0) begin errors++; $display("FAIL reset_data got %h exp 0", {out_data, out_r, out_c, win_r, win_c}); end
    checks++; if ({busy0, out_valid0, done0} !== 3'b0) begin errors++; $display("FAIL reset_dut0 got %b exp 000", {busy0, out_valid0, done0}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_pass();
    exp_q.delete();
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) exp_q.push_back({3'(r), 3'(c)});
    run_pass(110, -1, 0, 0);
    checks++; if (hs_cyc.size() != 25) begin errors++; $display("FAIL full_count got %0d exp 25", hs_cyc.size()); end
    for (int i = 0; i < 25 && i < hs_cyc.size(); i++) begin
      checks++; if (hs_cyc[i] != 4 + 4 * i) begin errors++; $display("FAIL full_cycle[%0d] got %0d exp %0d", i, hs_cyc[i], 4 + 4 * i); end
      checks++; if (hs_rc[i] !== exp_q[i]) begin errors++; $display("FAIL full_coord[%0d] got %h exp %h", i, hs_rc[i], exp_q[i]); end
      checks++; if (hs_d[i] !== pix(exp_q[i][5:3], exp_q[i][2:0])) begin errors++; $display("FAIL full_data[%0d] got %h exp %h", i, hs_d[i], pix(exp_q[i][5:3], exp_q[i][2:0])); end
      checks++; if (hs_last[i] !== (i == 24)) begin errors++; $display("FAIL full_last[%0d] got %b exp %b", i, hs_last[i], (i == 24)); end
    end
    checks++; if (done_q.size() != 1 || done_q[0] != 101) begin errors++; $display("FAIL full_done got n=%0d first=%0d exp n=1 at 101", done_q.size(), (done_q.size() > 0) ? done_q[0] : -1); end
    checks++; if ({busy_q[0], busy_q[1], busy_q[100], busy_q[101]} !== 4'b0110) begin errors++; $display("FAIL full_busy got %b exp 0110", {busy_q[0], busy_q[1], busy_q[100], busy_q[101]}); end
`ifdef CONV_POOL_SCHED_PERF_EN
    checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL full_stall got %0d exp 0", stall_cycles); end
`endif
  endtask

  task automatic test_ready_stall();
    use_const = 1'b1;
    run_pass(120, 8, 10, 0);
    checks++; if (st_d.size() != 10) begin errors++; $display("FAIL stall_len got %0d exp 10", st_d.size()); end
    for (int i = 0; i < st_d.size(); i++) begin
      checks++; if (st_d[i] !== 18'h2A5A5 || st_rc[i] !== 6'o13) begin errors++; $display("FAIL stall_hold[%0d] got %h/%o exp 2a5a5/13", i, st_d[i], st_rc[i]); end
      checks++; if (st_wv[i] !== 1'b0 || st_win[i] !== 6'o13) begin errors++; $display("FAIL stall_win[%0d] got %b/%o exp 0/13", i, st_wv[i], st_win[i]); end
    end
    checks++; if (hs_cyc.size() != 25) begin errors++; $display("FAIL stall_count got %0d exp 25", hs_cyc.size()); end
    if (hs_cyc.size() > 9) begin
      checks++; if (hs_cyc[8] != 46 || hs_rc[8] !== 6'o13) begin errors++; $display("FAIL stall_hs8 got %0d/%o exp 46/13", hs_cyc[8], hs_rc[8]); end
      checks++; if (hs_cyc[9] != 50 || hs_rc[9] !== 6'o14) begin errors++; $display("FAIL stall_hs9 got %0d/%o exp 50/14", hs_cyc[9], hs_rc[9]); end
      checks++; if (hs_d[9] !== 18'h2A5A5) begin errors++; $display("FAIL stall_data got %h exp 2a5a5", hs_d[9]); end
    end
    checks++; if (done_q.size() != 1 || done_q[0] != 111) begin errors++; $display("FAIL stall_done got n=%0d first=%0d exp n=1 at 111", done_q.size(), (done_q.size() > 0) ? done_q[0] : -1); end
`ifdef CONV_POOL_SCHED_PERF_EN
    checks++; if (stall_cycles !== 16'd10) begin errors++; $display("FAIL stall_cycles got %0d exp 10", stall_cycles); end
`endif
    use_const = 1'b0;
  endtask

  task automatic test_start_ignored();
    run_pass(110, -1, 0, 1);
    checks++; if (hs_cyc.size() != 25) begin errors++; $display("FAIL ign_count got %0d exp 25", hs_cyc.size()); end
    checks++; if (done_q.size() != 1 || done_q[0] != 101) begin errors++; $display("FAIL ign_done got n=%0d first=%0d exp n=1 at 101", done_q.size(), (done_q.size() > 0) ? done_q[0] : -1); end
    if (hs_cyc.size() == 25) begin
      checks++; if (hs_rc[0] !== 6'o00 || hs_rc[24] !== 6'o44 || hs_cyc[24] != 100) begin errors++; $display("FAIL ign_ends got %o %o @%0d exp 00 44 @100", hs_rc[0], hs_rc[24], hs_cyc[24]); end
    end
  endtask

  task automatic test_dp_lat0();
    int n = 0;
    int dcyc = -1;
    int dn = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      start0 = (cyc == 0);
      if (cyc == 1) begin
        checks++; if (busy0 !== 1'b1 || win_valid0 !== 1'b1) begin errors++; $display("FAIL lat0_busy got %b%b exp 11", busy0, win_valid0); end
      end
      if (out_valid0) begin
        checks++; if (cyc != 2 + 2 * n || {out_r0, out_c0} !== {3'(n / 5), 3'(n % 5)}) begin errors++; $display("FAIL lat0_hs[%0d] got %0d/%o exp %0d/%o", n, cyc, {out_r0, out_c0}, 2 + 2 * n, {3'(n / 5), 3'(n % 5)}); end
        checks++; if (out_data0 !== pix(3'(n / 5), 3'(n % 5))) begin errors++; $display("FAIL lat0_data[%0d] got %h exp %h", n, out_data0, pix(3'(n / 5), 3'(n % 5))); end
        n++;
      end
      if (done0) begin dcyc = cyc; dn++; end
      @(negedge clk);
    end
    start0 = 1'b0;
    checks++; if (n != 25) begin errors++; $display("FAIL lat0_count got %0d exp 25", n); end
    checks++; if (dn != 1 || dcyc != 51) begin errors++; $display("FAIL lat0_done got n=%0d at %0d exp n=1 at 51", dn, dcyc); end
  endtask

  task automatic test_back_to_back();
    run_pass(210, -1, 0, 2);
    checks++; if (done_q.size() < 2 || done_q[0] != 101 || done_q[1] != 203) begin errors++; $display("FAIL b2b_done got n=%0d exp 101,203", done_q.size()); end
    checks++; if ({busy_q[101], busy_q[102], busy_q[103]} !== 3'b001) begin errors++; $display("FAIL b2b_busy got %b exp 001", {busy_q[101], busy_q[102], busy_q[103]}); end
    checks++; if (hs_cyc.size() < 50) begin errors++; $display("FAIL b2b_count got %0d exp >=50", hs_cyc.size()); end
    if (hs_cyc.size() >= 50) begin
      checks++; if (hs_cyc[25] != 106) begin errors++; $display("FAIL b2b_first got %0d exp 106", hs_cyc[25]); end
      for (int i = 0; i < 25; i++) begin
        checks++; if (hs_rc[25 + i] !== exp_q[i]) begin errors++; $display("FAIL b2b_coord[%0d] got %o exp %o", i, hs_rc[25 + i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_mid_reset();
    int seen_done = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_pass(40, -1, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL mrst_state got %0d exp %0d", dbg_state, IDLE); end
    checks++; if ({out_valid, busy, done, win_valid} !== 4'b0) begin errors++; $display("FAIL mrst_flags got %b exp 0000", {out_valid, busy, done, win_valid}); end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (done) seen_done++;
      @(negedge clk);
    end
    checks++; if (done_q.size() != 0 || seen_done != 0) begin errors++; $display("FAIL mrst_nodone got %0d exp 0", done_q.size() + seen_done); end
    run_pass(8, -1, 0, 0);
    checks++; if (hs_cyc.size() < 1 || hs_cyc[0] != 4 || hs_rc[0] !== 6'o00) begin errors++; $display("FAIL mrst_restart got n=%0d exp first (0,0) at 4", hs_cyc.size()); end
  endtask

  initial begin
    test_reset();
    test_full_pass();
    test_ready_stall();
    test_start_ignored();
    test_dp_lat0();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
